imem_program_loader: RTL and testbench
======================================

# imem_program_loader

Byte-stream program loader that fills `instruction_memory` through its write port (`address`, `mode`, `write_data`) while the core is held off. It accepts a framed byte stream over a valid/ready handshake: length byte, big-endian 32-bit words, XOR checksum byte. It assembles each word and issues one single-cycle write per word at consecutive addresses. It asserts `cpu_hold` for the whole transfer so `command_runner` does not fetch half-loaded code.

## Interface
- `ADDR_W`, default 8: instruction-memory address width.
- `WORD_W`, default 32: instruction word width; fixed at 4 bytes.
- `clk`  in  1: sole clock, rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a load; ignored unless in IDLE.
- `base_addr`  in  ADDR_W: first write address, sampled on accepted `start`.
- `in_valid`  in  1: byte-stream valid.
- `in_data`  in  8: byte-stream data.
- `in_ready`  out  1: loader can accept a byte this cycle.
- `mem_address`  out  ADDR_W: to `instruction_memory.address`.
- `mem_mode`  out  1: to `instruction_memory.mode`; 0 = write, 1 = read/idle.
- `mem_write_data`  out  WORD_W: to `instruction_memory.write_data`.
- `cpu_hold`  out  1: core stall, high from accepted `start` through DONE.
- `done`  out  1: one-cycle pulse at the end of a frame.
- `err`  out  1: checksum mismatch; sticky until the next accepted `start`.

## Operation
- Frame format: byte L gives word count N = L+1 (1..256). Then 4·N payload bytes, MSB first per word. Then byte C = XOR of all 4·N payload bytes.
- A byte is accepted on a rising edge with `in_valid & in_ready`. `in_data` is ignored otherwise.
- States:
  - IDLE: `in_ready`=0, `cpu_hold`=0. Goes to LEN on `start`; latches `base_addr`, clears `err`, byte index, word counter and running XOR.
  - LEN: `in_ready`=1. On accept, latches L and goes to DATA.
  - DATA: `in_ready`=1. Shifts the byte into the word assembly register `{w[23:0],in_data}` and XORs it into the checksum. After the 4th byte of a word, goes to WRITE.
  - WRITE: `in_ready`=0. Drives `mem_mode`=0, `mem_address`=base+word_idx, `mem_write_data`=assembled word for exactly one cycle. Next state is DATA if word_idx≠L (word_idx increments), else CSUM.
  - CSUM: `in_ready`=1. On accept, sets `err` if running XOR ≠ byte, then goes to DONE.
  - DONE: one cycle. `done`=1, `cpu_hold`=1, then IDLE.
- Address arithmetic is modulo 2^ADDR_W: base+word_idx wraps past 255 to 0 without error.
- Words already written before a checksum failure stay in memory. `err` flags them and there is no rollback.
- `start` asserted in any state other than IDLE has no effect.
- Reset mid-frame: all state is lost; a partial word is never written. The sender must restart the frame after reset.

## Timing
- Reset values: `in_ready`=0, `mem_mode`=1, `mem_address`=0, `mem_write_data`=0, `cpu_hold`=0, `done`=0, `err`=0, state IDLE.
- All outputs are registered; none depends combinationally on `in_valid` or `in_data`.
- `cpu_hold` rises the cycle after `start` is accepted. It falls the cycle after DONE, the same cycle the state returns to IDLE.
- Write latency: the WRITE cycle immediately follows the cycle in which the 4th byte of the word was accepted. `instruction_memory` samples it on the rising edge that ends that cycle.
- With `in_valid` held high, throughput is 5 cycles per word (4 bytes + 1 WRITE). Total frame time is 1 + 5N + 1 + 1 cycles after `start`.
- Outside WRITE, `mem_mode`=1. `mem_address` and `mem_write_data` hold their last value; they are don't-care while `mem_mode`=1.
- Stalls: `in_valid` low for any number of cycles holds state and all outputs unchanged.

## Test plan
- Reset: hold `rst`=0 with random inputs, then release. All outputs are at reset values and `start` is required before `in_ready` rises.
- Single word: base 0x05, bytes 00, D5 E3 20 00, C=D5^E3^20^00=16. Expect exactly one `mem_mode`=0 cycle with addr 5, data 0xD5E32000, then `done` pulse, `err`=0, and `cpu_hold` low afterwards.
- Wrap and back-pressure: base 0xFE, L=02 (3 words), `in_valid` toggling 1/0. Writes go to 0xFE, 0xFF, 0x00 in order, each with exactly one write cycle, and no byte is lost or duplicated.
- Bad checksum: 2-word frame with C off by 0x01. Both words are written, `err`=1 after DONE, and the next `start` clears `err`.
- Reset mid-word: assert `rst` after 2 payload bytes of word 1. No write for that word, `mem_mode` returns to 1 asynchronously, and a fresh frame then loads correctly.
- Ignored start: pulse `start` with new `base_addr` during DATA. Addresses continue from the original base.

Source files
------------

// File: rtl/imem_program_loader.sv
// Loads a framed byte stream (length, big-endian words, XOR checksum) into
// instruction memory through its write port while the core is held off.
module imem_program_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_mode,
    output logic [WORD_W-1:0] mem_write_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        word_idx, word_idx_d;
    logic [1:0]        byte_idx, byte_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        xor_q, xor_d;
    logic              err_d;
    logic              accept;

    // in_ready is a registered decode of the state, so accept never
    // depends combinationally on anything but in_valid at the flop inputs.
    assign accept = in_valid & in_ready;

    always_comb begin
        state_d    = state;
        base_d     = base_q;
        len_d      = len_q;
        word_idx_d = word_idx;
        byte_idx_d = byte_idx;
        word_d     = word_q;
        xor_d      = xor_q;
        err_d      = err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LEN;
                    base_d     = base_addr;
                    err_d      = 1'b0;
                    byte_idx_d = 2'd0;
                    word_idx_d = 8'd0;
                    xor_d      = 8'd0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d   = in_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d     = {word_q[WORD_W-9:0], in_data};
                    xor_d      = xor_q ^ in_data;
                    byte_idx_d = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (word_idx == len_q) begin
                    state_d = S_CSUM;
                end else begin
                    word_idx_d = word_idx + 8'd1;
                    state_d    = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (xor_q != in_data) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each one lines up with
    // the state it belongs to without a combinational path to the stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            base_q         <= '0;
            len_q          <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            word_q         <= '0;
            xor_q          <= '0;
            in_ready       <= 1'b0;
            mem_mode       <= 1'b1;
            mem_address    <= '0;
            mem_write_data <= '0;
            cpu_hold       <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state    <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            word_idx <= word_idx_d;
            byte_idx <= byte_idx_d;
            word_q   <= word_d;
            xor_q    <= xor_d;
            err      <= err_d;
            in_ready <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
            mem_mode <= (state_d != S_WRITE);
            cpu_hold <= (state_d != S_IDLE);
            done     <= (state_d == S_DONE);
            if (state_d == S_WRITE) begin
                mem_address    <= base_q + ADDR_W'(word_idx);
                mem_write_data <= word_d;
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed frame table plus hand-written reset and ignored-start sequences
// for imem_program_loader.
module tb_imem_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  mem_address;
    logic        mem_mode;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int done_count = 0;
    int done_cyc   = 0;
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    typedef struct packed {
        logic [7:0]       base;
        logic [7:0]       n;
        logic [2:0][31:0] w;
        logic [7:0]       delta;
        logic             toggle;
        logic             inject;
        logic [2:0][7:0]  addr;
        logic             exp_err;
    } frame_t;

    frame_t tbl[5];

    imem_program_loader #(.ADDR_W(8), .WORD_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_mode       (mem_mode),
        .mem_write_data (mem_write_data),
        .cpu_hold       (cpu_hold),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port and done monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst && !mem_mode) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_write_data);
        end
        if (rst && done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic frame_t make_frame(input logic [7:0] base, input logic [7:0] n,
                                          input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [7:0] delta,
                                          input logic toggle, input logic inject,
                                          input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic exp_err);
        frame_t f;
        f.base = base; f.n = n; f.delta = delta; f.toggle = toggle; f.inject = inject;
        f.w[0] = w0; f.w[1] = w1; f.w[2] = w2;
        f.addr[0] = a0; f.addr[1] = a1; f.addr[2] = a2;
        f.exp_err = exp_err;
        return f;
    endfunction

    // Offers one byte and returns just after the edge that accepted it.
    task automatic apply_stimulus(input logic [7:0] b, input logic gap);
        int t = 0;
        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            check_output("byte_accept_timeout", 32'(t), 32'd0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] base, output int start_cyc);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_frame(input frame_t f, input string tag);
        logic [7:0] cs;
        int start_cyc;
        int wr_base;
        int done_base;
        wr_base   = wr_addr_q.size();
        done_base = done_count;
        cs = 8'h00;
        pulse_start(f.base, start_cyc);
        check_output({tag, "_hold_rise"}, 32'(cpu_hold), 32'd1);
        check_output({tag, "_err_clear"}, 32'(err), 32'd0);
        apply_stimulus(f.n - 8'd1, f.toggle);
        for (int i = 0; i < int'(f.n); i++) begin
            for (int b = 3; b >= 0; b--) begin
                logic [7:0] by;
                by = f.w[i][8*b +: 8];
                cs = cs ^ by;
                if (f.inject && i == 1 && b == 2) begin
                    start     = 1'b1;
                    base_addr = 8'h80;
                end
                apply_stimulus(by, f.toggle);
                start = 1'b0;
            end
        end
        apply_stimulus(cs ^ f.delta, f.toggle);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check_output({tag, "_done_count"}, 32'(done_count - done_base), 32'd1);
        check_output({tag, "_err"}, 32'(err), 32'(f.exp_err));
        check_output({tag, "_hold_fall"}, 32'(cpu_hold), 32'd0);
        check_output({tag, "_ready_idle"}, 32'(in_ready), 32'd0);
        check_output({tag, "_write_count"}, 32'(wr_addr_q.size() - wr_base), 32'(f.n));
        for (int i = 0; i < int'(f.n); i++) begin
            if (wr_base + i < wr_addr_q.size()) begin
                check_output({tag, "_addr"}, 32'(wr_addr_q[wr_base + i]), 32'(f.addr[i]));
                check_output({tag, "_data"}, wr_data_q[wr_base + i], f.w[i]);
            end
        end
        if (!f.toggle) begin
            check_output({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(5 * int'(f.n) + 2));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_output({tag, "_mem_mode"}, 32'(mem_mode), 32'd1);
        check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int wr_before;
        int sc;
        rst = 1'b0; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0; in_data = 8'h00;

        tbl[0] = make_frame(8'h05, 8'd1, 32'hD5E32000, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0,
                            8'h05, 8'h00, 8'h00, 1'b0);
        tbl[1] = make_frame(8'hFE, 8'd3, 32'h11223344, 32'hA5A5A5A5, 32'h0F0E0D0C, 8'h00, 1'b1, 1'b0,
                            8'hFE, 8'hFF, 8'h00, 1'b0);
        tbl[2] = make_frame(8'h10, 8'd2, 32'hDEADBEEF, 32'h01020304, 32'h0, 8'h01, 1'b0, 1'b0,
                            8'h10, 8'h11, 8'h00, 1'b1);
        tbl[3] = make_frame(8'h20, 8'd1, 32'hCAFEF00D, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0,
                            8'h20, 8'h00, 8'h00, 1'b0);
        tbl[4] = make_frame(8'h40, 8'd2, 32'h00000001, 32'hFFFF0000, 32'h0, 8'h00, 1'b0, 1'b1,
                            8'h40, 8'h41, 8'h00, 1'b0);

        // Reset held with random inputs.
        repeat (5) begin
            @(negedge clk);
            start     = 1'($urandom);
            base_addr = 8'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            #1;
            check_reset_outputs("in_reset");
        end
        check_output("rst_mem_address", 32'(mem_address), 32'h00);
        check_output("rst_mem_data", mem_write_data, 32'h0);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("after_release");
        check_output("no_write_without_start", 32'(wr_addr_q.size()), 32'd0);
        in_valid = 1'b0;

        foreach (tbl[k]) begin
            run_frame(tbl[k], $sformatf("frame%0d", k));
        end

        // Reset after two payload bytes of the second word.
        wr_before = wr_addr_q.size();
        pulse_start(8'h30, sc);
        apply_stimulus(8'h01, 1'b0);
        apply_stimulus(8'hAA, 1'b0);
        apply_stimulus(8'hBB, 1'b0);
        apply_stimulus(8'hCC, 1'b0);
        apply_stimulus(8'hDD, 1'b0);
        apply_stimulus(8'h11, 1'b0);
        apply_stimulus(8'h22, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midword_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("midword_write_count", 32'(wr_addr_q.size() - wr_before), 32'd1);
        if (wr_before < wr_addr_q.size()) begin
            check_output("midword_addr", 32'(wr_addr_q[wr_before]), 32'h30);
            check_output("midword_data", wr_data_q[wr_before], 32'hAABBCCDD);
        end

        // Reset during the write cycle must release mem_mode without a clock edge.
        pulse_start(8'h50, sc);
        apply_stimulus(8'h00, 1'b0);
        apply_stimulus(8'h12, 1'b0);
        apply_stimulus(8'h34, 1'b0);
        apply_stimulus(8'h56, 1'b0);
        apply_stimulus(8'h78, 1'b0);
        check_output("write_cycle_mode", 32'(mem_mode), 32'd0);
        #1 rst = 1'b0;
        #1;
        check_output("async_mem_mode", 32'(mem_mode), 32'd1);
        check_output("async_cpu_hold", 32'(cpu_hold), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(make_frame(8'h60, 8'd1, 32'h89ABCDEF, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0,
                             8'h60, 8'h00, 8'h00, 1'b0), "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
